// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, FSM state encodings and operand edge constants.
package alu_pkg;

    localparam int unsigned DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_BUSY  = 2'd1,
        DIV_FIXUP = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN      = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/alu_subtractor.sv
// Combinational two's-complement subtractor shared by the ALU execute stage.
module alu_subtractor #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dif,
    output logic             ovf
);

    assign dif = a - b;
    // Signed overflow: operands differ in sign and result sign differs from a.
    assign ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (dif[WIDTH-1] ^ a[WIDTH-1]);

endmodule

// File: rtl/alu_divider.sv
// Iterative restoring divider: one trial subtraction per cycle, signed/unsigned,
// with divide-by-zero and MIN/-1 short-cuts and a held result until out_ready.
module alu_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int unsigned      CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_V    = {WIDTH{1'b1}};

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             ovf_q, ovf_d;

    // The stored remainder never exceeds the divisor, so its guard bit only
    // exists in the shifted value; only WIDTH bits need a register.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] trial_a;
    logic [WIDTH-1:0] trial_dif;
    logic             sub_ovf_unused;
    logic             borrow;
    logic             take;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial_a   = rem_shift[WIDTH-1:0];

    alu_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a   (trial_a),
        .b   (dsr_q),
        .dif (trial_dif),
        .ovf (sub_ovf_unused)
    );

    assign borrow = (~trial_a[WIDTH-1] & dsr_q[WIDTH-1])
                  | (~(trial_a[WIDTH-1] ^ dsr_q[WIDTH-1]) & trial_dif[WIDTH-1]);
    assign take   = rem_shift[WIDTH] | ~borrow;

    assign dividend_abs = (op_signed && dividend[WIDTH-1]) ? (~dividend) + WIDTH'(1) : dividend;
    assign divisor_abs  = (op_signed && divisor[WIDTH-1])  ? (~divisor) + WIDTH'(1)  : divisor;

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dsr_d         = dsr_q;
        cnt_d         = cnt_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        ovf_d         = ovf_q;

        case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    quotient_d    = '0;
                    remainder_d   = '0;
                    div_by_zero_d = 1'b0;
                    ovf_d         = 1'b0;
                    if (divisor == '0) begin
                        quotient_d    = ONES_V;
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                        state_d       = DIV_DONE;
                    end else if (op_signed && dividend == MIN_V && divisor == ONES_V) begin
                        quotient_d = MIN_V;
                        ovf_d      = 1'b1;
                        state_d    = DIV_DONE;
                    end else begin
                        quo_d     = dividend_abs;
                        dsr_d     = divisor_abs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = op_signed & dividend[WIDTH-1];
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                rem_d = take ? trial_dif : rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], take};
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_FIXUP;
                end
            end
            DIV_FIXUP: begin
                quotient_d  = neg_quo_q ? (~quo_q) + WIDTH'(1) : quo_q;
                remainder_d = neg_rem_q ? (~rem_q) + WIDTH'(1) : rem_q;
                state_d     = DIV_DONE;
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        in_ready_d  = (state_d == DIV_IDLE);
        out_valid_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= DIV_IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            cnt_q         <= cnt_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            ovf_q         <= ovf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: hand-computed quotients, flags, latency, hold and reset abort.
module tb_alu_divider;
    import alu_pkg::*;

    localparam int unsigned W       = 64;
    localparam int          MAX_LAT = 200;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         ovf;

    int n_checks;
    int n_pass;

    alu_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_signed   (op_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Present one operand pair, scramble the inputs after the accept edge and
    // return the number of edges (accept edge included) until out_valid.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, output int lat);
        @(negedge clk);
        check({tag, " in_ready"}, W'(in_ready), W'(1));
        op_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op_signed = ~sgn;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < MAX_LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ov);
        check({tag, " quotient"},  quotient,        q);
        check({tag, " remainder"}, remainder,       r);
        check({tag, " div_by_zero"}, W'(div_by_zero), W'(dbz));
        check({tag, " ovf"},       W'(ovf),         W'(ov));
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_valid", W'(out_valid), W'(0));
        expect_res("reset", '0, '0, 1'b0, 1'b0);

        run_div("u100/7", 1'b0, 64'd100, 64'd7, lat);
        check("u100/7 latency", W'(lat), W'(66));
        check("u100/7 in_ready", W'(in_ready), W'(0));
        expect_res("u100/7", 64'd14, 64'd2, 1'b0, 1'b0);
        ack();

        run_div("s-100/7", 1'b1, -64'sd100, 64'd7, lat);
        check("s-100/7 latency", W'(lat), W'(66));
        expect_res("s-100/7", -64'sd14, -64'sd2, 1'b0, 1'b0);
        ack();

        run_div("s100/-7", 1'b1, 64'd100, -64'sd7, lat);
        expect_res("s100/-7", -64'sd14, 64'd2, 1'b0, 1'b0);
        ack();

        run_div("s-7/-2", 1'b1, -64'sd7, -64'sd2, lat);
        expect_res("s-7/-2", 64'd3, -64'sd1, 1'b0, 1'b0);
        ack();

        run_div("uones/1", 1'b0, DIV_ALL_ONES, 64'd1, lat);
        expect_res("uones/1", DIV_ALL_ONES, 64'd0, 1'b0, 1'b0);
        ack();

        run_div("umin/3", 1'b0, DIV_MIN, 64'd3, lat);
        expect_res("umin/3", 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 1'b0);
        ack();

        run_div("smin/2", 1'b1, DIV_MIN, 64'd2, lat);
        expect_res("smin/2", 64'hC000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
        ack();

        run_div("smin/-1", 1'b1, DIV_MIN, DIV_ALL_ONES, lat);
        check("smin/-1 latency", W'(lat), W'(1));
        expect_res("smin/-1", DIV_MIN, 64'd0, 1'b0, 1'b1);
        ack();

        run_div("div0", 1'b0, 64'h1234, 64'd0, lat);
        check("div0 latency", W'(lat), W'(1));
        expect_res("div0", DIV_ALL_ONES, 64'h1234, 1'b1, 1'b0);
        ack();

        // Hold the result; a competing request must be ignored while DONE.
        run_div("hold", 1'b0, 64'd1000, 64'd10, lat);
        op_signed = 1'b0;
        dividend  = 64'd55;
        divisor   = 64'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold out_valid", W'(out_valid), W'(1));
            check("hold in_ready", W'(in_ready), W'(0));
            expect_res("hold", 64'd100, 64'd0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        ack();
        check("release in_ready", W'(in_ready), W'(1));
        check("release out_valid", W'(out_valid), W'(0));
        run_div("after-hold 7/2", 1'b0, 64'd7, 64'd2, lat);
        expect_res("after-hold 7/2", 64'd3, 64'd1, 1'b0, 1'b0);
        ack();

        // Abort a divide at step 30 with reset.
        @(negedge clk);
        op_signed = 1'b0;
        dividend  = 64'd1000;
        divisor   = 64'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready", W'(in_ready), W'(1));
        check("abort out_valid", W'(out_valid), W'(0));
        expect_res("abort", '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("abort no result", W'(out_valid), W'(0));
        run_div("9/3", 1'b0, 64'd9, 64'd3, lat);
        check("9/3 latency", W'(lat), W'(66));
        expect_res("9/3", 64'd3, 64'd0, 1'b0, 1'b0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
